// File: rtl/median_pkg.sv
// Shared types and constants for the median window sequencer.
package median_pkg;

    localparam int unsigned SETTLE_CYC = 2;
    localparam int unsigned MED_CNT_W  = 8;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StSettle1,
        StSettle2,
        StOut
    } med_state_e;

    // A programmed length of zero still runs a one-sample window.
    function automatic logic [MED_CNT_W-1:0] clamp_len(input logic [MED_CNT_W-1:0] len);
        return (len == '0) ? MED_CNT_W'(1) : len;
    endfunction

endpackage

// File: rtl/median_ctrl.sv
// Window sequencer for the median Sorter: clear, fill, settle, capture, then hand the
// result downstream on a valid/ready handshake.
module median_ctrl
    import median_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned DEPTH     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic [MED_CNT_W-1:0] win_len_i,
    input  logic [DATA_SIZE-1:0] din_i,
    input  logic                 din_valid_i,
    output logic                 din_ready_o,
    output logic                 sort_rst_o,
    output logic                 sort_valid_o,
    output logic [DATA_SIZE-1:0] sort_din_o,
    input  logic [DATA_SIZE-1:0] sort_do_i,
    input  logic [MED_CNT_W-1:0] sort_ncells_i,
    output logic [DATA_SIZE-1:0] med_o,
    output logic [MED_CNT_W-1:0] med_cells_o,
    output logic                 med_sat_o,
    output logic                 med_valid_o,
    input  logic                 med_ready_i,
    output logic                 busy_o
);

    med_state_e             state_q;
    logic [MED_CNT_W-1:0]   len_q;
    logic [MED_CNT_W-1:0]   cnt_q;
    logic                   din_ready_q;
    logic                   sort_rst_q;
    logic                   busy_q;
    logic [DATA_SIZE-1:0]   med_q;
    logic [MED_CNT_W-1:0]   med_cells_q;
    logic                   med_sat_q;
    logic                   med_valid_q;
    logic                   accept;

    // din_ready_q is only ever set while in FILL, so it doubles as the FILL qualifier.
    assign accept = din_valid_i & din_ready_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            len_q       <= MED_CNT_W'(1);
            cnt_q       <= '0;
            din_ready_q <= 1'b0;
            sort_rst_q  <= 1'b1;
            busy_q      <= 1'b0;
            med_q       <= '0;
            med_cells_q <= '0;
            med_sat_q   <= 1'b0;
            med_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enable_i) begin
                        len_q       <= clamp_len(win_len_i);
                        cnt_q       <= '0;
                        din_ready_q <= 1'b1;
                        sort_rst_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= StFill;
                    end
                end
                StFill: begin
                    // Abort wins over a simultaneous final accept.
                    if (!enable_i) begin
                        din_ready_q <= 1'b0;
                        sort_rst_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end else if (accept) begin
                        cnt_q <= cnt_q + MED_CNT_W'(1);
                        if (cnt_q == len_q - MED_CNT_W'(1)) begin
                            din_ready_q <= 1'b0;
                            state_q     <= StSettle1;
                        end
                    end
                end
                StSettle1: begin
                    state_q <= StSettle2;
                end
                StSettle2: begin
                    med_q       <= sort_do_i;
                    med_cells_q <= sort_ncells_i;
                    med_sat_q   <= (sort_ncells_i == MED_CNT_W'(DEPTH));
                    med_valid_q <= 1'b1;
                    state_q     <= StOut;
                end
                StOut: begin
                    if (med_ready_i) begin
                        med_valid_q <= 1'b0;
                        sort_rst_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign din_ready_o  = din_ready_q;
    assign sort_rst_o   = sort_rst_q;
    assign sort_valid_o = accept;
    assign sort_din_o   = din_i;
    assign med_o        = med_q;
    assign med_cells_o  = med_cells_q;
    assign med_sat_o    = med_sat_q;
    assign med_valid_o  = med_valid_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_median_ctrl.sv
// Self-checking bench: two sequencers (depth 16 and 4) share stimulus, each beside a Sorter model.
module tb_median_ctrl;

    typedef logic [7:0] cells_t [16];

    typedef struct {
        logic [7:0] med;
        logic [7:0] cells;
        logic       sat;
        logic [7:0] med4;
        logic [7:0] cells4;
        logic       sat4;
        logic       med4_ok;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] win_len = 8'd1;
    logic [7:0] din = 8'd0;
    logic       din_valid = 1'b0;
    logic       med_ready = 1'b1;

    logic       din_ready16, sort_rst16, sort_valid16, med_sat16, med_valid16, busy16;
    logic [7:0] sort_din16, sort_do16, nc16, med16, med_cells16;
    logic       din_ready4, sort_rst4, sort_valid4, med_sat4, med_valid4, busy4;
    logic [7:0] sort_din4, sort_do4, nc4, med4, med_cells4;

    cells_t c16, c4;
    int     n16 = 0, n4 = 0;
    int     checks = 0, errors = 0;
    exp_t   sb[$];
    logic [7:0] smp [8];

    always #5 clk = ~clk;

    median_ctrl #(.DATA_SIZE(8), .DEPTH(16)) dut16 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .win_len_i(win_len),
        .din_i(din), .din_valid_i(din_valid), .din_ready_o(din_ready16),
        .sort_rst_o(sort_rst16), .sort_valid_o(sort_valid16), .sort_din_o(sort_din16),
        .sort_do_i(sort_do16), .sort_ncells_i(nc16), .med_o(med16),
        .med_cells_o(med_cells16), .med_sat_o(med_sat16), .med_valid_o(med_valid16),
        .med_ready_i(med_ready), .busy_o(busy16)
    );

    median_ctrl #(.DATA_SIZE(8), .DEPTH(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .win_len_i(win_len),
        .din_i(din), .din_valid_i(din_valid), .din_ready_o(din_ready4),
        .sort_rst_o(sort_rst4), .sort_valid_o(sort_valid4), .sort_din_o(sort_din4),
        .sort_do_i(sort_do4), .sort_ncells_i(nc4), .med_o(med4),
        .med_cells_o(med_cells4), .med_sat_o(med_sat4), .med_valid_o(med_valid4),
        .med_ready_i(med_ready), .busy_o(busy4)
    );

    // Sorter model: ascending distinct cells, largest dropped when full.
    function automatic cells_t sort_ins(cells_t a, int n, int depth, logic [7:0] v);
        cells_t r;
        int pos;
        r = a;
        pos = n;
        for (int i = 0; i < n; i++) if (a[i] == v) return a;
        for (int i = n - 1; i >= 0; i--) if (a[i] > v) pos = i;
        if (pos >= depth) return a;
        for (int i = 1; i < 16; i++) if (i > pos && i < depth) r[i] = a[i-1];
        r[pos] = v;
        return r;
    endfunction

    function automatic int sort_cnt(cells_t a, int n, int depth, logic [7:0] v);
        for (int i = 0; i < n; i++) if (a[i] == v) return n;
        return (n < depth) ? n + 1 : n;
    endfunction

    always @(posedge clk) begin
        if (sort_rst16) begin
            n16 <= 0;
            nc16 <= 8'd0;
        end else begin
            if (sort_valid16) begin
                c16 <= sort_ins(c16, n16, 16, sort_din16);
                n16 <= sort_cnt(c16, n16, 16, sort_din16);
            end
            nc16 <= 8'(n16);
        end
    end

    always @(posedge clk) begin
        if (sort_rst4) begin
            n4 <= 0;
            nc4 <= 8'd0;
        end else begin
            if (sort_valid4) begin
                c4 <= sort_ins(c4, n4, 4, sort_din4);
                n4 <= sort_cnt(c4, n4, 4, sort_din4);
            end
            nc4 <= 8'(n4);
        end
    end

    assign sort_do16 = c16[int'(nc16) >> 1];
    assign sort_do4  = c4[int'(nc4) >> 1];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected result from the sample list: sorted distinct values, median at index n>>1.
    function automatic exp_t expect_of(int n);
        exp_t e;
        logic [7:0] d [8];
        int nd = 0;
        for (int i = 0; i < n; i++) begin
            bit dup = 1'b0;
            for (int j = 0; j < nd; j++) if (d[j] == smp[i]) dup = 1'b1;
            if (!dup) begin
                int p = nd;
                while (p > 0 && d[p-1] > smp[i]) begin
                    d[p] = d[p-1];
                    p--;
                end
                d[p] = smp[i];
                nd++;
            end
        end
        e.cells   = 8'(nd);
        e.med     = d[nd >> 1];
        e.sat     = (nd == 16);
        e.cells4  = (nd > 4) ? 8'd4 : 8'(nd);
        e.sat4    = (nd >= 4);
        e.med4_ok = (nd <= 4);
        e.med4    = d[((nd > 4) ? 4 : nd) >> 1];
        return e;
    endfunction

    // Scoreboard consumer: compare at each downstream handshake.
    always @(negedge clk) begin
        if (rst_n && med_valid16 && med_ready) begin
            check_eq("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check_eq("med", med16, e.med);
                check_eq("med_cells", med_cells16, e.cells);
                check_eq("med_sat", med_sat16, e.sat);
                check_eq("d4_valid", med_valid4, 1);
                check_eq("d4_cells", med_cells4, e.cells4);
                check_eq("d4_sat", med_sat4, e.sat4);
                if (e.med4_ok) check_eq("d4_med", med4, e.med4);
            end
        end
    end

    task automatic start_window(input logic [7:0] len);
        win_len = len;
        enable = 1'b1;
        @(posedge clk); #1;
        check_eq("fill_ready", din_ready16, 1);
        check_eq("fill_sort_rst", sort_rst16, 0);
        check_eq("fill_busy", busy16, 1);
    endtask

    // Feeds n samples; optionally one bubble after the second and a latency check.
    task automatic feed(input int n, input bit bubble, input bit lat);
        sb.push_back(expect_of(n));
        for (int i = 0; i < n; i++) begin
            if (bubble && i == 2) begin
                din_valid = 1'b0;
                @(posedge clk); #1;
                check_eq("bubble_ready", din_ready16, 1);
            end
            din = smp[i];
            din_valid = 1'b1;
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
        enable = 1'b0;
        if (lat) begin
            @(negedge clk);
            check_eq("settle1_valid", med_valid16, 0);
            check_eq("settle1_ready", din_ready16, 0);
            @(negedge clk);
            check_eq("settle2_valid", med_valid16, 0);
            @(negedge clk);
            check_eq("out_valid", med_valid16, 1);
            @(negedge clk);
            check_eq("pulse_end", med_valid16, 0);
            check_eq("idle_sort_rst", sort_rst16, 1);
            check_eq("idle_busy", busy16, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [7:0] held;
        bit found;
        #1 rst_n = 1'b0;
        din_valid = 1'b1;
        #1;
        check_eq("rst_sort_rst", sort_rst16, 1);
        check_eq("rst_busy", busy16, 0);
        check_eq("rst_ready", din_ready16, 0);
        check_eq("rst_sort_valid", sort_valid16, 0);
        check_eq("rst_med_valid", med_valid16, 0);
        din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        smp = '{8'd3, 8'd7, 8'd1, 8'd9, 8'd5, 8'd0, 8'd0, 8'd0};
        start_window(8'd5);
        feed(5, 1'b0, 1'b1);

        smp = '{8'd4, 8'd4, 8'd4, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0};
        start_window(8'd4);
        feed(4, 1'b1, 1'b1);

        smp = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd0, 8'd0};
        start_window(8'd6);
        feed(6, 1'b0, 1'b1);

        // Downstream stall in OUT.
        med_ready = 1'b0;
        smp = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        start_window(8'd3);
        feed(3, 1'b0, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            @(negedge clk);
            found = med_valid16;
        end
        check_eq("stall_reached_out", 32'(found), 1);
        held = med16;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("stall_valid", med_valid16, 1);
            check_eq("stall_med", med16, 32'(held));
            check_eq("stall_ready", din_ready16, 0);
        end
        @(posedge clk); #1;
        win_len = 8'd5;
        enable = 1'b1;
        med_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("post_hs_sort_rst", sort_rst16, 1);
        check_eq("post_hs_ready", din_ready16, 0);
        @(posedge clk); #1;
        check_eq("next_fill_ready", din_ready16, 1);

        // Abort after two samples; they must not leak into the next window.
        din = 8'd100;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din = 8'd200;
        @(posedge clk); #1;
        din_valid = 1'b0;
        enable = 1'b0;
        @(posedge clk); #1;
        check_eq("abort_busy", busy16, 0);
        check_eq("abort_sort_rst", sort_rst16, 1);
        check_eq("abort_valid", med_valid16, 0);
        smp = '{8'd9, 8'd8, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        start_window(8'd3);
        feed(3, 1'b0, 1'b1);

        // Asynchronous reset mid-FILL.
        start_window(8'd4);
        din = 8'd77;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din = 8'd66;
        @(posedge clk); #1;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_sort_rst", sort_rst16, 1);
        check_eq("arst_busy", busy16, 0);
        check_eq("arst_ready", din_ready16, 0);
        check_eq("arst_sort_valid", sort_valid16, 0);
        check_eq("arst_med", med16, 0);
        check_eq("arst_cells", med_cells16, 0);
        din_valid = 1'b0;
        enable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        smp = '{8'd42, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        start_window(8'd0);
        feed(1, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        check_eq("sb_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/median_ctrl.md
# median_ctrl

Window sequencer for the median Sorter: it clears the Sorter, feeds a programmable number of samples from an upstream valid/ready stream, and waits for the Sorter's registered cell count to settle. It then captures the median and its distinct-value count, and presents them downstream on a valid/ready handshake. It sits between a sample source (e.g. an APV channel pedestal path) and the Sorter instance, which sits beside it at the same hierarchy level.

## Interface
- DATA_SIZE, 8: sample width; must match the Sorter's data_size.
- DEPTH, 16: Sorter depth (number of cells), 1..255.
- CLK  in  1  clock.
- RSTn  in  1  asynchronous active-low reset (one clock, async active-low reset, as decided).
- ENABLE  in  1  start and continue windows; low aborts the current window.
- WIN_LEN  in  8  samples per window; latched when leaving IDLE; 0 is treated as 1.
- DIN  in  DATA_SIZE  upstream sample.
- DIN_VALID  in  1  upstream valid.
- DIN_READY  out  1  high in FILL only.
- SORT_RST  out  1  Sorter synchronous reset, active-high.
- SORT_VALID  out  1  Sorter VALID.
- SORT_DIN  out  DATA_SIZE  Sorter DIN.
- SORT_DO  in  DATA_SIZE  Sorter median output.
- SORT_NCELLS  in  8  Sorter occupied-cell count.
- MED  out  DATA_SIZE  captured median.
- MED_CELLS  out  8  captured distinct count.
- MED_SAT  out  1  captured SORT_NCELLS == DEPTH; values may have been dropped.
- MED_VALID  out  1  result valid.
- MED_READY  in  1  downstream accept.
- BUSY  out  1  state != IDLE.

## Operation
- States: IDLE, FILL, SETTLE1, SETTLE2, OUT.
- **IDLE**
  - SORT_RST=1, which holds the Sorter cleared.
  - If ENABLE: latch len = max(WIN_LEN,1), clear sample counter cnt, go to FILL.
- **FILL**
  - DIN_READY=1.
  - SORT_VALID = DIN_VALID and SORT_DIN = DIN, combinational pass-through.
  - On each accept (DIN_VALID & DIN_READY): cnt+1.
  - Accept with cnt == len-1: go to SETTLE1.
  - ENABLE low: go to IDLE with no result; this takes priority over a simultaneous final accept.
- **SETTLE1, SETTLE2**
  - One cycle each; SORT_VALID=0.
  - SETTLE2 edge: MED<=SORT_DO, MED_CELLS<=SORT_NCELLS, MED_SAT<=(SORT_NCELLS==DEPTH); go to OUT.
  - ENABLE is ignored in these states.
- **OUT**
  - MED_VALID=1; MED, MED_CELLS and MED_SAT are held stable.
  - On MED_READY: go to IDLE.
  - ENABLE is ignored; a result is never dropped once captured.
- cnt is 8-bit and compared only against len, so it never wraps.
- SORT_DIN=DIN in all states; SORT_VALID=0 outside FILL.
- Duplicate samples are discarded by the Sorter, so MED_CELLS ≤ accepted samples. The median is the Sorter's cell[N>>1] over distinct values.

## Timing
- Reset (RSTn low, async):
  - state=IDLE, so SORT_RST=1 and BUSY=0.
  - MED=0, MED_CELLS=0, MED_SAT=0, MED_VALID=0, DIN_READY=0, SORT_VALID=0, cnt=0, len=1.
  - Release is synchronous to CLK.
- Reset mid-window discards all state; the Sorter is cleared on the first CLK edge with RSTn high.
- Latency: if edge E accepts the final sample, capture happens at E+2 and MED_VALID is high in the cycle after E+2.
  - SETTLE is fixed at 2 cycles: 1 for Sorter cells, 1 for the registered N_CELLS.
- Minimum window period with MED_READY tied high: len + 4 cycles (FILL len, SETTLE 2, OUT 1, IDLE 1).
- The IDLE cycle is the Sorter clear; it is mandatory between windows.
- Upstream sees DIN_READY=1 for exactly the FILL cycles; bubbles on DIN_VALID stretch FILL.

## Structure
- Package median_pkg:
  - state enum (IDLE, FILL, SETTLE1, SETTLE2, OUT);
  - SETTLE_CYC=2;
  - MED_CNT_W=8.
- Single flat module, no sub-module needed.
- The Sorter is instantiated alongside it by the parent; a thin parent median_filter wiring the two is natural.

## Test plan
- DEPTH=16, WIN_LEN=5, DIN 3,7,1,9,5 back-to-back, MED_READY=1 -> MED=5, MED_CELLS=5, MED_SAT=0. MED_VALID rises in the cycle after the 2nd edge after the final accept and stays high 1 cycle.
- WIN_LEN=4, DIN 4,4,4,2 -> MED_CELLS=2, MED=4.
- DEPTH=4, WIN_LEN=6, DIN 10,20,30,40,50,60 -> MED_CELLS=4, MED_SAT=1.
- MED_READY low for 10 cycles in OUT -> MED_VALID and MED stable throughout. DIN_READY stays 0. The next window starts only after the handshake plus 1 IDLE cycle with SORT_RST=1.
- ENABLE dropped after 2 of 5 samples -> return to IDLE, no MED_VALID. Restart with 9,8,7 and WIN_LEN=3 -> MED=8; prior samples must not leak.
- RSTn pulsed low mid-FILL -> all outputs at reset values asynchronously, SORT_RST=1. WIN_LEN=0 window with DIN=42 -> MED=42, MED_CELLS=1.
